// File: rtl/bsg_manycore_pkt_encode_pipe.sv
// Registered manycore packet encoder with store-credit and load-id tracking.
// Packet layout (MSB..LSB): addr, op, op_ex, load_id, payload, src_y, src_x, y, x.
// Op encoding: 0 = load, 1 = store, 2 = swap-acquire, 3 = swap-release.
module bsg_manycore_pkt_encode_pipe #(
    parameter int x_cord_width_p       = 6,
    parameter int y_cord_width_p       = 6,
    parameter int data_width_p         = 32,
    parameter int addr_width_p         = 25,
    parameter int load_id_width_p      = 5,
    parameter int epa_addr_width_p     = 17,
    parameter int dram_ch_addr_width_p = 24,
    parameter int num_dram_ch_p        = 4,
    parameter int dram_ch_start_col_p  = 0,
    parameter int max_out_credits_p    = 16,
    parameter int max_out_loads_p      = 8,
    localparam int mask_width_lp   = data_width_p / 8,
    localparam int packet_width_lp = addr_width_p + 2 + mask_width_lp + load_id_width_p
                                     + data_width_p + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  logic [31:0]                 addr_i,
    input  logic [data_width_p-1:0]     data_i,
    input  logic [mask_width_lp-1:0]    mask_i,
    input  logic                        we_i,
    input  logic                        swap_aq_i,
    input  logic                        swap_rl_i,
    input  logic [x_cord_width_p-1:0]   my_x_i,
    input  logic [y_cord_width_p-1:0]   my_y_i,
    input  logic [x_cord_width_p-1:0]   tile_group_x_i,
    input  logic [y_cord_width_p-1:0]   tile_group_y_i,
    output logic                        v_o,
    output logic [packet_width_lp-1:0]  data_o,
    input  logic                        ready_i,
    input  logic                        credit_v_i,
    input  logic                        load_return_v_i,
    input  logic [load_id_width_p-1:0]  load_return_id_i,
    output logic                        error_v_o,
    output logic [credit_width_lp-1:0]  credits_o,
    output logic [max_out_loads_p-1:0]  loads_busy_o
);

    typedef enum logic [1:0] {
        op_load    = 2'd0,
        op_store   = 2'd1,
        op_swap_aq = 2'd2,
        op_swap_rl = 2'd3
    } op_e;

    localparam int dram_ch_bits_lp = $clog2(num_dram_ch_p);
    localparam logic [31:0] dram_ch_mask_lp = (32'd1 << dram_ch_bits_lp) - 32'd1;

    logic [31:0]                 dram_ch;
    logic                        is_dram, is_global, is_remote, is_network, is_loadlike;
    logic [x_cord_width_p-1:0]   pkt_x;
    logic [y_cord_width_p-1:0]   pkt_y;
    logic [addr_width_p-1:0]     pkt_addr;
    op_e                         pkt_op;
    logic [load_id_width_p-1:0]  pkt_load_id, free_id;
    logic                        has_free;
    logic                        fifo_full, accept_net, deq;
    logic [packet_width_lp-1:0]  pkt;
    logic [packet_width_lp-1:0]  fifo_mem [2];
    logic                        wr_ptr, rd_ptr;
    logic [1:0]                  fifo_count;
    logic                        credits_full, credit_return;
    logic [max_out_loads_p-1:0]  return_mask, alloc_mask, clear_mask;

    // Address decode and per-class field extraction; DRAM wins over global over remote.
    always_comb begin
        dram_ch   = (addr_i >> dram_ch_addr_width_p) & dram_ch_mask_lp;
        is_dram   = addr_i[31] && (dram_ch < 32'(num_dram_ch_p));
        is_global = (addr_i[31:30] == 2'b01);
        is_remote = (addr_i[31:29] == 3'b001);
        is_network = is_dram || is_global || is_remote;
        pkt_x    = '0;
        pkt_y    = '0;
        pkt_addr = '0;
        if (addr_i[31]) begin
            pkt_x    = x_cord_width_p'(dram_ch + 32'(dram_ch_start_col_p));
            pkt_y    = '1;
            pkt_addr = addr_width_p'({1'b0, addr_i[dram_ch_addr_width_p-1:0]});
        end else if (is_global) begin
            pkt_x    = x_cord_width_p'(addr_i[22:17]);
            pkt_y    = y_cord_width_p'(addr_i[28:23]);
            pkt_addr = addr_width_p'(addr_i[epa_addr_width_p-1:0]);
        end else begin
            pkt_x    = x_cord_width_p'(addr_i[22:17]) + tile_group_x_i;
            pkt_y    = y_cord_width_p'(addr_i[28:23]) + tile_group_y_i;
            pkt_addr = addr_width_p'(addr_i[epa_addr_width_p-1:0]);
        end
        if (swap_aq_i)      pkt_op = op_swap_aq;
        else if (swap_rl_i) pkt_op = op_swap_rl;
        else if (we_i)      pkt_op = op_store;
        else                pkt_op = op_load;
        is_loadlike = (pkt_op != op_store);
    end

    // Lowest-index free load id, taken from the registered busy vector only.
    always_comb begin
        has_free = 1'b0;
        free_id  = '0;
        for (int i = max_out_loads_p - 1; i >= 0; i--) begin
            if (!loads_busy_o[i]) begin
                has_free = 1'b1;
                free_id  = load_id_width_p'(i);
            end
        end
    end

    // Acceptance and packet assembly; non-network requests are always consumed.
    always_comb begin
        fifo_full  = (fifo_count == 2'd2);
        ready_o    = is_network ? (!fifo_full && (credits_o != '0) && (!is_loadlike || has_free))
                                : 1'b1;
        accept_net = v_i && ready_o && is_network;
        pkt_load_id = is_loadlike ? free_id : '0;
        pkt = {pkt_addr, pkt_op, mask_i, pkt_load_id, data_i, my_y_i, my_x_i, pkt_y, pkt_x};
    end

    // One-hot masks for the load id being allocated and the one being returned.
    always_comb begin
        return_mask = '0;
        alloc_mask  = '0;
        for (int i = 0; i < max_out_loads_p; i++) begin
            return_mask[i] = load_return_v_i && (load_return_id_i == load_id_width_p'(i));
            alloc_mask[i]  = accept_net && is_loadlike && (free_id == load_id_width_p'(i));
        end
        clear_mask = return_mask & loads_busy_o;
    end

    assign deq     = v_o && ready_i;
    assign v_o     = (fifo_count != 2'd0);
    assign data_o  = fifo_mem[rd_ptr];
    assign credits_full  = (credits_o == credit_width_lp'(max_out_credits_p));
    assign credit_return = credit_v_i && !credits_full;

    // Two-entry output FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (accept_net) wr_ptr <= ~wr_ptr;
            if (deq)        rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, accept_net} - {1'b0, deq};
        end
    end

    // FIFO storage; contents are don't-care while the entry is empty.
    always_ff @(posedge clk_i) begin
        if (accept_net) fifo_mem[wr_ptr] <= pkt;
    end

    // Store credits: spend on accept, refund on credit return, saturate at the maximum.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_o <= credit_width_lp'(max_out_credits_p);
        end else if (accept_net && !credit_return) begin
            credits_o <= credits_o - credit_width_lp'(1);
        end else if (!accept_net && credit_return) begin
            credits_o <= credits_o + credit_width_lp'(1);
        end
    end

    // Busy load ids and the one-cycle error pulse for consumed non-network requests.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            loads_busy_o <= '0;
            error_v_o    <= 1'b0;
        end else begin
            loads_busy_o <= (loads_busy_o & ~clear_mask) | alloc_mask;
            error_v_o    <= v_i && !is_network;
        end
    end

`ifndef SYNTHESIS
    // Flag protocol misuse from the core or the network in simulation.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (credit_v_i && credits_full)
                $error("credit returned while credit count is already at maximum");
            if (load_return_v_i && (clear_mask == '0))
                $error("load return for id %0d which is not busy", load_return_id_i);
            if (v_i && !is_network && (swap_aq_i || swap_rl_i))
                $error("swap issued to a non-network address %h", addr_i);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_encode_pipe.sv
// Scoreboard bench for bsg_manycore_pkt_encode_pipe with a behavioural model.
module tb_bsg_manycore_pkt_encode_pipe;

    localparam int XW   = 4;
    localparam int YW   = 3;
    localparam int DW   = 32;
    localparam int AW   = 20;
    localparam int LW   = 3;
    localparam int MAXC = 4;
    localparam int MAXL = 3;
    localparam int PW   = AW + 2 + DW / 8 + LW + DW + 2 * (XW + YW);
    localparam int CW   = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          req_v, ready;
    logic [31:0]   addr;
    logic [DW-1:0] data;
    logic [3:0]    mask;
    logic          we, swap_aq, swap_rl;
    logic [XW-1:0] my_x, tg_x;
    logic [YW-1:0] my_y, tg_y;
    logic          pkt_v;
    logic [PW-1:0] pkt;
    logic          router_ready, credit_v, load_return_v;
    logic [LW-1:0] load_return_id;
    logic          error_v;
    logic [CW-1:0] credits;
    logic [MAXL-1:0] loads_busy;

    int total = 0;
    int bad   = 0;

    int             m_credits;
    bit             m_busy [MAXL];
    int             m_fifo;
    bit             m_err;
    logic [PW-1:0]  exp_q [$];

    always #5 clk = ~clk;

    bsg_manycore_pkt_encode_pipe #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW),
        .load_id_width_p(LW), .epa_addr_width_p(17), .dram_ch_addr_width_p(24),
        .num_dram_ch_p(3), .dram_ch_start_col_p(2),
        .max_out_credits_p(MAXC), .max_out_loads_p(MAXL)
    ) dut (
        .clk_i(clk), .reset_i(reset), .v_i(req_v), .ready_o(ready), .addr_i(addr),
        .data_i(data), .mask_i(mask), .we_i(we), .swap_aq_i(swap_aq), .swap_rl_i(swap_rl),
        .my_x_i(my_x), .my_y_i(my_y), .tile_group_x_i(tg_x), .tile_group_y_i(tg_y),
        .v_o(pkt_v), .data_o(pkt), .ready_i(router_ready), .credit_v_i(credit_v),
        .load_return_v_i(load_return_v), .load_return_id_i(load_return_id),
        .error_v_o(error_v), .credits_o(credits), .loads_busy_o(loads_busy)
    );

    // Network addresses: DRAM with a channel below 3, global, or remote.
    function automatic bit model_is_net(input logic [31:0] a);
        int unsigned ua;
        ua = a;
        if (ua >= 32'h8000_0000) return ((ua / 32'h0100_0000) % 4) < 3;
        return ua >= 32'h2000_0000;
    endfunction

    function automatic logic [PW-1:0] model_packet(input logic [31:0] a, input logic w,
                                                   input logic aq, input logic rl,
                                                   input logic [3:0] m, input logic [31:0] d,
                                                   input int id);
        int unsigned ua, px, py, pa, op, lid;
        ua = a;
        if (ua >= 32'h8000_0000) begin
            px = (((ua / 32'h0100_0000) % 4) + 2) % 16;
            py = 7;
            pa = (ua % 32'h0100_0000) % 32'h0010_0000;
        end else if (ua >= 32'h4000_0000) begin
            px = (ua / 32'h0002_0000) % 16;
            py = (ua / 32'h0080_0000) % 8;
            pa = ua % 32'h0002_0000;
        end else begin
            px = ((ua / 32'h0002_0000) % 64 + int'(tg_x)) % 16;
            py = ((ua / 32'h0080_0000) % 64 + int'(tg_y)) % 8;
            pa = ua % 32'h0002_0000;
        end
        op  = aq ? 2 : (rl ? 3 : (w ? 1 : 0));
        lid = (op == 1) ? 0 : id;
        return {AW'(pa), 2'(op), m, LW'(lid), d, my_y, my_x, YW'(py), XW'(px)};
    endfunction

    task automatic compare(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_credits = MAXC;
        for (int i = 0; i < MAXL; i++) m_busy[i] = 1'b0;
        m_fifo = 0;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    // Registered outputs against the model state at the start of a cycle.
    task automatic check_output();
        logic [MAXL-1:0] busy_exp;
        for (int i = 0; i < MAXL; i++) busy_exp[i] = m_busy[i];
        compare("v_o", 64'(pkt_v), 64'(m_fifo != 0));
        compare("credits_o", 64'(credits), 64'(m_credits));
        compare("loads_busy_o", 64'(loads_busy), 64'(busy_exp));
        compare("error_v_o", 64'(error_v), 64'(m_err));
    endtask

    // Inputs are already set; predict ready, advance the model, step one clock.
    task automatic apply_stimulus();
        bit net, loadlike, acc, deq, exp_ready;
        int id;
        check_output();
        #1;
        if (reset) begin
            m_reset();
        end else begin
            net      = model_is_net(addr);
            loadlike = swap_aq || swap_rl || !we;
            id = -1;
            for (int i = MAXL - 1; i >= 0; i--) if (!m_busy[i]) id = i;
            exp_ready = net ? (m_fifo < 2 && m_credits > 0 && (!loadlike || id >= 0)) : 1'b1;
            if (req_v) compare("ready_o", 64'(ready), 64'(exp_ready));
            acc = req_v && exp_ready && net;
            deq = (m_fifo > 0) && router_ready;
            if (acc) begin
                exp_q.push_back(model_packet(addr, we, swap_aq, swap_rl, mask, data,
                                             loadlike ? id : 0));
                m_credits--;
                if (loadlike) m_busy[id] = 1'b1;
            end
            if (credit_v) m_credits++;
            if (load_return_v) m_busy[load_return_id] = 1'b0;
            m_fifo = m_fifo + int'(acc) - int'(deq);
            m_err  = req_v && !net;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        reset = 1'b0; req_v = 1'b0; addr = '0; data = '0; mask = '0;
        we = 1'b0; swap_aq = 1'b0; swap_rl = 1'b0; router_ready = 1'b0;
        credit_v = 1'b0; load_return_v = 1'b0; load_return_id = '0;
    endtask

    task automatic set_req(input logic [31:0] a, input logic w, input logic aq, input logic rl);
        req_v = 1'b1; addr = a; we = w; swap_aq = aq; swap_rl = rl;
        data = $urandom; mask = 4'($urandom_range(0, 15));
    endtask

    // Drain the FIFO and hand back every outstanding credit and load id.
    task automatic recover();
        for (int k = 0; k < 24; k++) begin
            set_idle();
            router_ready = 1'b1;
            if (m_credits < MAXC) credit_v = 1'b1;
            for (int i = MAXL - 1; i >= 0; i--) begin
                if (m_busy[i]) begin
                    load_return_v  = 1'b1;
                    load_return_id = LW'(i);
                end
            end
            apply_stimulus();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] b;
        int cat;
        b   = $urandom;
        cat = $urandom_range(0, 9);
        if (cat <= 2)      return 32'h2000_0000 + (b % 32'h2000_0000);
        else if (cat <= 4) return 32'h4000_0000 + (b % 32'h4000_0000);
        else if (cat <= 7) return b | 32'h8000_0000;
        else               return b % 32'h2000_0000;
    endfunction

    // Scoreboard monitor: every handshaken packet must match the oldest expectation.
    always @(negedge clk) begin
        if (pkt_v && router_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL packet: got %h expected none at %0t", pkt, $time);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                if (pkt !== e) begin
                    bad++;
                    $display("[TB] FAIL packet: got %h expected %h at %0t", pkt, e, $time);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int r;
        int busy_ids [$];
        set_idle();
        my_x = 4'd5; my_y = 3'd6; tg_x = 4'd2; tg_y = 3'd1;
        reset = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus();

        // Remote store, DRAM load, invalid DRAM channel, global store.
        set_idle(); router_ready = 1'b1; set_req(32'h2060_0010, 1'b1, 1'b0, 1'b0); apply_stimulus();
        set_idle(); router_ready = 1'b1; apply_stimulus();
        set_idle(); router_ready = 1'b1; set_req(32'h8200_0040, 1'b0, 1'b0, 1'b0); apply_stimulus();
        set_idle(); router_ready = 1'b1; apply_stimulus();
        set_idle(); router_ready = 1'b1; set_req(32'h8300_0040, 1'b1, 1'b0, 1'b0); apply_stimulus();
        set_idle(); router_ready = 1'b1; apply_stimulus();
        set_idle(); router_ready = 1'b1; set_req(32'h5234_5678, 1'b1, 1'b0, 1'b0); apply_stimulus();
        recover();

        // Back-pressure: the third store must stall, then all drain in order.
        for (int k = 0; k < 3; k++) begin
            set_idle(); set_req(32'h2000_0100 + 32'(k * 4), 1'b1, 1'b0, 1'b0); apply_stimulus();
        end
        for (int k = 0; k < 3; k++) begin
            set_idle(); router_ready = 1'b1; apply_stimulus();
        end
        recover();

        // Exhaust load ids; a same-cycle return is not reusable until the next cycle.
        for (int k = 0; k < 4; k++) begin
            set_idle(); router_ready = 1'b1; set_req(32'h8100_0000 + 32'(k * 4), 1'b0, 1'b0, 1'b0);
            apply_stimulus();
        end
        set_idle(); router_ready = 1'b1; set_req(32'h8100_0100, 1'b0, 1'b0, 1'b0);
        load_return_v = 1'b1; load_return_id = '0; apply_stimulus();
        set_idle(); router_ready = 1'b1; set_req(32'h8100_0100, 1'b0, 1'b0, 1'b0); apply_stimulus();
        recover();

        // Credit return coinciding with an accept leaves the count unchanged.
        set_idle(); router_ready = 1'b1; set_req(32'h2000_0200, 1'b1, 1'b0, 1'b0); apply_stimulus();
        set_idle(); router_ready = 1'b1; set_req(32'h2000_0204, 1'b1, 1'b0, 1'b0);
        credit_v = 1'b1; apply_stimulus();
        recover();

        // Randomised traffic with back-pressure, credit returns and load returns.
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            router_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) != 0) begin
                a = rand_addr();
                r = model_is_net(a) ? $urandom_range(0, 9) : 9;
                set_req(a, 1'($urandom_range(0, 1)), r == 0, r == 1);
            end
            if (m_credits < MAXC && $urandom_range(0, 9) < 4) credit_v = 1'b1;
            busy_ids.delete();
            for (int i = 0; i < MAXL; i++) if (m_busy[i]) busy_ids.push_back(i);
            if (busy_ids.size() > 0 && $urandom_range(0, 9) < 3) begin
                load_return_v  = 1'b1;
                load_return_id = LW'(busy_ids[$urandom_range(0, busy_ids.size() - 1)]);
            end
            apply_stimulus();
        end
        recover();

        // Reset while the FIFO is full and resources are in use.
        set_idle(); set_req(32'h2000_0300, 1'b1, 1'b0, 1'b0); apply_stimulus();
        set_idle(); set_req(32'h8000_0300, 1'b0, 1'b0, 1'b0); apply_stimulus();
        set_idle(); reset = 1'b1; apply_stimulus();
        set_idle(); apply_stimulus();
        set_idle(); router_ready = 1'b1; apply_stimulus();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL leftover: got %0d pending packets expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
